rd_fram_ctrl: RTL and testbench

RD_FRAM_CTRL -- requirements
Module: rd_fram_ctrl

---
 rtl/rd_fram_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_rd_fram_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_fram_ctrl.sv
// Line-fetch read controller: splits each video line into DDR read bursts and
// writes the returned beats into a two-bank line buffer. RD_FRAM_CTRL_STAT_EN adds a completed-line counter.
module rd_fram_ctrl #(
  parameter int ADDR_W      = 28,
  parameter int FRAME_BASE  = 0,
  parameter int LINE_BEATS  = 256,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_LINES = 720
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              line_req,
  output logic              rd_cmd_valid,
  input  logic              rd_cmd_ready,
  output logic [ADDR_W-1:0] rd_cmd_addr,
  output logic [7:0]        rd_cmd_len,
  input  logic              rd_data_valid,
  input  logic [255:0]      rd_data,
  output logic              buf_wr_en,
  output logic [8:0]        buf_wr_addr,
  output logic [255:0]      buf_wr_data,
  output logic              line_done,
  output logic              busy,
  output logic              err_overrun,
  output logic [15:0]       stat_line_cnt
);

  localparam int LC_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [LC_W-1:0]   line_cnt_r, line_cnt_s;
  logic              bank_r, bank_s;
  logic [7:0]        burst_idx_r, burst_idx_s;
  logic [7:0]        beat_idx_r, beat_idx_s;
  logic              pending_r, pending_s;
  logic              fs_latch_r, fs_latch_s;
  logic              restart_s, overrun_req_s, stray_beat_s;
  logic              burst_end_s, line_end_s, wr_beat_s;
  logic [ADDR_W-1:0] addr_s;

  logic              rd_cmd_valid_r, buf_wr_en_r, line_done_r, busy_r, err_overrun_r;
  logic [ADDR_W-1:0] rd_cmd_addr_r;
  logic [7:0]        rd_cmd_len_r;
  logic [8:0]        buf_wr_addr_r;
  logic [255:0]      buf_wr_data_r;

  // A restart (direct or deferred) is only ever applied while idle
  assign restart_s    = (state_r == IDLE) && (frame_start || fs_latch_r);
  assign stray_beat_s = rd_data_valid && (state_r != DATA);
  assign wr_beat_s    = rd_data_valid && (state_r == DATA);
  assign burst_end_s  = (beat_idx_r & 8'(BURST_LEN - 1)) == 8'(BURST_LEN - 1);
  assign line_end_s   = beat_idx_r == 8'(LINE_BEATS - 1);
  assign addr_s       = ADDR_W'(FRAME_BASE) + ADDR_W'(line_cnt_s) * ADDR_W'(LINE_BEATS)
                      + ADDR_W'(burst_idx_s) * ADDR_W'(BURST_LEN);

  // Next-state, request queueing and index bookkeeping
  always_comb begin
    state_s       = state_r;
    line_cnt_s    = line_cnt_r;
    bank_s        = bank_r;
    burst_idx_s   = burst_idx_r;
    beat_idx_s    = beat_idx_r;
    pending_s     = pending_r;
    fs_latch_s    = fs_latch_r;
    overrun_req_s = 1'b0;

    // A request arriving while one is already queued is dropped
    if ((state_r == IDLE) && (frame_start || pending_r)) begin
      pending_s = line_req;
    end else if (line_req) begin
      pending_s     = 1'b1;
      overrun_req_s = pending_r;
    end else begin
      pending_s = pending_r;
    end

    if ((state_r != IDLE) && frame_start) begin
      fs_latch_s = 1'b1;
    end else if (restart_s) begin
      fs_latch_s = 1'b0;
    end else begin
      fs_latch_s = fs_latch_r;
    end

    case (state_r)
      IDLE: begin
        line_cnt_s = restart_s ? '0 : line_cnt_r;
        bank_s     = restart_s ? 1'b0 : bank_r;
        if (pending_r && !frame_start) begin
          state_s = CMD;
        end else begin
          state_s = IDLE;
        end
      end
      CMD: begin
        if (rd_cmd_ready) begin
          state_s = DATA;
        end else begin
          state_s = CMD;
        end
      end
      DATA: begin
        if (rd_data_valid && burst_end_s && line_end_s) begin
          state_s     = DONE;
          beat_idx_s  = 8'd0;
          burst_idx_s = 8'd0;
        end else if (rd_data_valid && burst_end_s) begin
          state_s     = CMD;
          beat_idx_s  = beat_idx_r + 8'd1;
          burst_idx_s = burst_idx_r + 8'd1;
        end else if (rd_data_valid) begin
          state_s    = DATA;
          beat_idx_s = beat_idx_r + 8'd1;
        end else begin
          state_s = DATA;
        end
      end
      DONE: begin
        state_s    = IDLE;
        bank_s     = ~bank_r;
        line_cnt_s = (line_cnt_r == LC_W'(FRAME_LINES - 1)) ? '0 : line_cnt_r + 1'b1;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are derived from next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      line_cnt_r     <= '0;
      bank_r         <= 1'b0;
      burst_idx_r    <= 8'd0;
      beat_idx_r     <= 8'd0;
      pending_r      <= 1'b0;
      fs_latch_r     <= 1'b0;
      rd_cmd_valid_r <= 1'b0;
      rd_cmd_addr_r  <= '0;
      rd_cmd_len_r   <= 8'd0;
      buf_wr_en_r    <= 1'b0;
      buf_wr_addr_r  <= 9'd0;
      buf_wr_data_r  <= 256'd0;
      line_done_r    <= 1'b0;
      busy_r         <= 1'b0;
      err_overrun_r  <= 1'b0;
    end else begin
      state_r        <= state_s;
      line_cnt_r     <= line_cnt_s;
      bank_r         <= bank_s;
      burst_idx_r    <= burst_idx_s;
      beat_idx_r     <= beat_idx_s;
      pending_r      <= pending_s;
      fs_latch_r     <= fs_latch_s;
      rd_cmd_valid_r <= (state_s == CMD);
      buf_wr_en_r    <= wr_beat_s;
      line_done_r    <= (state_s == DONE);
      busy_r         <= (state_s != IDLE);
      err_overrun_r  <= err_overrun_r | overrun_req_s | stray_beat_s;
      if (state_s == CMD) begin
        rd_cmd_addr_r <= addr_s;
        rd_cmd_len_r  <= 8'(BURST_LEN - 1);
      end
      if (wr_beat_s) begin
        buf_wr_addr_r <= {bank_r, beat_idx_r};
        buf_wr_data_r <= rd_data;
      end
    end
  end

`ifdef RD_FRAM_CTRL_STAT_EN
  logic [15:0] stat_r;

  // Saturating completed-line counter, cleared together with the line counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_r <= 16'h0000;
    end else if (restart_s) begin
      stat_r <= 16'h0000;
    end else if ((state_r == DONE) && (stat_r != 16'hFFFF)) begin
      stat_r <= stat_r + 16'h0001;
    end
  end

  assign stat_line_cnt = stat_r;
`else
  assign stat_line_cnt = 16'h0000;
`endif

  assign rd_cmd_valid = rd_cmd_valid_r;
  assign rd_cmd_addr  = rd_cmd_addr_r;
  assign rd_cmd_len   = rd_cmd_len_r;
  assign buf_wr_en    = buf_wr_en_r;
  assign buf_wr_addr  = buf_wr_addr_r;
  assign buf_wr_data  = buf_wr_data_r;
  assign line_done    = line_done_r;
  assign busy         = busy_r;
  assign err_overrun  = err_overrun_r;

endmodule

// File: tb/tb_rd_fram_ctrl.sv
// Directed bench for rd_fram_ctrl with a DDR responder model and command/write
// scoreboards; expected stat_line_cnt follows RD_FRAM_CTRL_STAT_EN.
module tb_rd_fram_ctrl;

  localparam int ADDR_W = 28;
  localparam int FB     = 0;
  localparam int LB     = 256;
  localparam int BL     = 16;
  localparam int FL     = 2;
`ifdef RD_FRAM_CTRL_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              line_req = 1'b0;
  logic              rd_cmd_valid;
  logic              rd_cmd_ready = 1'b1;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic [7:0]        rd_cmd_len;
  logic              rd_data_valid = 1'b0;
  logic [255:0]      rd_data = 256'd0;
  logic              buf_wr_en;
  logic [8:0]        buf_wr_addr;
  logic [255:0]      buf_wr_data;
  logic              line_done;
  logic              busy;
  logic              err_overrun;
  logic [15:0]       stat_line_cnt;

  rd_fram_ctrl #(
    .ADDR_W(ADDR_W), .FRAME_BASE(FB), .LINE_BEATS(LB), .BURST_LEN(BL), .FRAME_LINES(FL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_req(line_req),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_len(rd_cmd_len), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .line_done(line_done), .busy(busy), .err_overrun(err_overrun),
    .stat_line_cnt(stat_line_cnt)
  );

  always #5 clk = ~clk;

  int                tests = 0;
  int                fails = 0;
  logic [ADDR_W-1:0] cmd_q[$];
  logic [8:0]        wa_q[$];
  logic [255:0]      wd_q[$];
  int                beats_left = 0;
  logic [ADDR_W-1:0] resp_addr = '0;
  bit                acc_q = 1'b0;
  logic [ADDR_W-1:0] acc_addr = '0;
  int                n_cmd = 0, n_wr = 0, n_done = 0;
  int                exp_line = 0;
  bit                exp_bank = 1'b0;
  logic [ADDR_W-1:0] exp_a;
  logic [8:0]        exp_wa;
  logic [255:0]      exp_wd;

  function automatic logic [255:0] pat(input logic [ADDR_W-1:0] a);
    pat = {8{4'hA, a ^ 28'h5A5_A5A5}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: handshake sampled before the edge, responder drives after it, writes checked at negedge
  task automatic tick();
    if (rd_cmd_valid && rd_cmd_ready) begin
      acc_q    = 1'b1;
      acc_addr = rd_cmd_addr;
      n_cmd++;
      check("cmd_expected", 256'(cmd_q.size() > 0), 256'(1'b1));
      if (cmd_q.size() > 0) begin
        exp_a = cmd_q.pop_front();
        check("cmd_addr", 256'(rd_cmd_addr), 256'(exp_a));
      end
      check("cmd_len", 256'(rd_cmd_len), 256'(8'd15));
    end
    @(posedge clk);
    if (acc_q) begin
      beats_left = BL;
      resp_addr  = acc_addr;
      acc_q      = 1'b0;
    end
    #1;
    if (beats_left > 0) begin
      rd_data_valid = 1'b1;
      rd_data       = pat(resp_addr);
      resp_addr++;
      beats_left--;
    end else begin
      rd_data_valid = 1'b0;
    end
    @(negedge clk);
    if (buf_wr_en) begin
      n_wr++;
      check("wr_expected", 256'(wa_q.size() > 0), 256'(1'b1));
      if (wa_q.size() > 0) begin
        exp_wa = wa_q.pop_front();
        exp_wd = wd_q.pop_front();
        check("wr_addr", 256'(buf_wr_addr), 256'(exp_wa));
        check("wr_data", buf_wr_data, exp_wd);
      end
    end
    if (line_done) n_done++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_line();
    for (int b = 0; b < LB / BL; b++) cmd_q.push_back(ADDR_W'(FB + exp_line * LB + b * BL));
    for (int i = 0; i < LB; i++) begin
      wa_q.push_back({exp_bank, 8'(i)});
      wd_q.push_back(pat(ADDR_W'(FB + exp_line * LB + i)));
    end
    exp_line = (exp_line + 1) % FL;
    exp_bank = ~exp_bank;
  endtask

  task automatic pulse_req();
    line_req = 1'b1;
    tick();
    line_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while ((cmd_q.size() > 0 || wa_q.size() > 0 || busy) && t < 3000) begin
      tick();
      t++;
    end
    check({tag, "_in_time"}, 256'(t < 3000), 256'(1'b1));
  endtask

  initial begin
    int c0, w0, d0, t;

    // reset state
    ticks(3);
    check("rst_valid", 256'(rd_cmd_valid), 256'(1'b0));
    check("rst_busy", 256'(busy), 256'(1'b0));
    check("rst_wr_en", 256'(buf_wr_en), 256'(1'b0));
    check("rst_line_done", 256'(line_done), 256'(1'b0));
    check("rst_err", 256'(err_overrun), 256'(1'b0));
    check("rst_stat", 256'(stat_line_cnt), 256'(16'h0000));
    check("rst_addr", 256'(rd_cmd_addr), 256'(28'd0));
    check("rst_len", 256'(rd_cmd_len), 256'(8'd0));
    check("rst_wr_addr", 256'(buf_wr_addr), 256'(9'd0));
    check("rst_wr_data", buf_wr_data, 256'd0);
    rst_n = 1'b1;
    tick();

    // line 0 into bank 0, then line 1 into bank 1, then wrap back to line 0 / bank 0
    c0 = n_cmd; w0 = n_wr; d0 = n_done;
    push_line();
    pulse_req();
    tick();
    check("busy_mid_line", 256'(busy), 256'(1'b1));
    wait_done("line0");
    check("line0_cmds", 256'(n_cmd - c0), 256'(16));
    check("line0_writes", 256'(n_wr - w0), 256'(256));
    check("line0_done", 256'(n_done - d0), 256'(1));
    push_line();
    pulse_req();
    wait_done("line1");
    push_line();
    pulse_req();
    wait_done("line2");
    check("three_lines_done", 256'(n_done - d0), 256'(3));
    check("stat_after_3", 256'(stat_line_cnt), 256'(STAT ? 16'd3 : 16'd0));

    // command held while ready is low
    rd_cmd_ready = 1'b0;
    c0 = n_cmd;
    push_line();
    pulse_req();
    t = 0;
    while (!rd_cmd_valid && t < 20) begin tick(); t++; end
    check("hold_valid_seen", 256'(rd_cmd_valid), 256'(1'b1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 256'(rd_cmd_valid), 256'(1'b1));
      check("hold_addr", 256'(rd_cmd_addr), 256'(cmd_q[0]));
      check("hold_len", 256'(rd_cmd_len), 256'(8'd15));
    end
    check("hold_no_accept", 256'(n_cmd - c0), 256'(0));
    rd_cmd_ready = 1'b1;
    wait_done("hold");
    check("hold_cmds", 256'(n_cmd - c0), 256'(16));

    // three requests during one fetch: two lines, overrun on the third
    d0 = n_done;
    push_line();
    push_line();
    pulse_req();
    ticks(5);
    pulse_req();
    ticks(3);
    check("ovr_not_yet", 256'(err_overrun), 256'(1'b0));
    pulse_req();
    check("ovr_set", 256'(err_overrun), 256'(1'b1));
    wait_done("ovr");
    ticks(4);
    check("ovr_two_lines", 256'(n_done - d0), 256'(2));
    check("ovr_idle", 256'(busy), 256'(1'b0));

    // reset mid-line: no line_done, late beats ignored and flagged
    d0 = n_done;
    push_line();
    pulse_req();
    ticks(20);
    t = 0;
    while (beats_left != 10 && t < 100) begin tick(); t++; end
    check("mid_burst_reached", 256'(beats_left), 256'(10));
    rst_n = 1'b0;
    tick();
    check("mrst_busy", 256'(busy), 256'(1'b0));
    check("mrst_valid", 256'(rd_cmd_valid), 256'(1'b0));
    check("mrst_err", 256'(err_overrun), 256'(1'b0));
    tick();
    rst_n = 1'b1;
    cmd_q.delete(); wa_q.delete(); wd_q.delete();
    exp_line = 0; exp_bank = 1'b0;
    w0 = n_wr;
    ticks(12);
    check("mrst_no_writes", 256'(n_wr - w0), 256'(0));
    check("mrst_no_done", 256'(n_done - d0), 256'(0));
    check("mrst_stray_err", 256'(err_overrun), 256'(1'b1));

    // frame_start mid-line: line completes, next request restarts at line 0 / bank 0
    push_line();
    pulse_req();
    wait_done("fs_a");
    d0 = n_done;
    push_line();
    pulse_req();
    ticks(30);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_done("fs_b");
    check("fs_line_completed", 256'(n_done - d0), 256'(1));
    exp_line = 0; exp_bank = 1'b0;
    push_line();
    pulse_req();
    wait_done("fs_c");

    // frame_start and line_req together in IDLE
    exp_line = 0; exp_bank = 1'b0;
    push_line();
    frame_start = 1'b1;
    line_req = 1'b1;
    tick();
    frame_start = 1'b0;
    line_req = 1'b0;
    wait_done("fs_req");
    check("stat_after_restart", 256'(stat_line_cnt), 256'(STAT ? 16'd1 : 16'd0));
    c0 = n_cmd;
    ticks(5);
    check("final_idle", 256'(busy), 256'(1'b0));
    check("final_no_cmd", 256'(n_cmd - c0), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
